systolic_result_drainer: RTL and testbench

//  Read-out end of the systolic array. On a drain request it snapshots the flattened result

---
 rtl/systolic_result_drainer_pkg.sv | 15 +
 rtl/systolic_sat_clamp.sv | 34 +++
 rtl/systolic_result_drainer.sv | 105 ++++++++++
 tb/tb_systolic_result_drainer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_result_drainer_pkg.sv
// Shared types and helpers for the systolic result drainer: FSM state encoding
// and the row-index width rule used by the top level.
package systolic_result_drainer_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_e;

    // A single-row array still needs a 1-bit row index port.
    function automatic int row_idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/systolic_sat_clamp.sv
// Combinational signed clamp of one IN_W-bit accumulator to OUT_W bits,
// with a flag raised whenever the value had to be limited.
module systolic_sat_clamp #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  in_val,
    output logic [OUT_W-1:0] out_val,
    output logic             sat
);

    if (OUT_W >= IN_W) begin : g_pass
        assign out_val = in_val[OUT_W-1:0];
        assign sat     = 1'b0;
    end else begin : g_clamp
        // The value fits when every dropped bit equals the new sign bit.
        logic [IN_W-OUT_W:0] top_bits;
        logic                fits;

        assign top_bits = in_val[IN_W-1:OUT_W-1];
        assign fits     = (top_bits == '0) || (top_bits == '1);

        // NOTE: every output gets a value on every path, so no latch is inferred.
        always_comb begin
            sat     = !fits;
            out_val = in_val[OUT_W-1:0];
            if (!fits) begin
                out_val = in_val[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                         : {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/systolic_result_drainer.sv
// Snapshots the PE array result matrix on a drain request and streams it out
// one clamped row per beat over a valid/ready handshake.
module systolic_result_drainer
    import systolic_result_drainer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int OUT_WIDTH  = 16,
    localparam int ACC_W     = 2 * DATA_WIDTH,
    localparam int ROW_W     = row_idx_width(ROWS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       drain,
    input  logic [ACC_W*ROWS*COLS-1:0] C_in,
    output logic                       drain_ack,
    output logic                       busy,
    output logic [COLS*OUT_WIDTH-1:0]  out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ROW_W-1:0]           out_row,
    output logic                       out_last,
    output logic                       out_sat
);

    localparam int ROW_BITS = COLS * ACC_W;

    drain_state_e            state;
    logic                    capture;
    logic [ROW_BITS-1:0]     snap [ROWS];
    logic [ROW_BITS-1:0]     cur_row;
    logic [COLS*OUT_WIDTH-1:0] clamped;
    logic [COLS-1:0]         sat_col;

    assign capture = (state == IDLE) && drain;

    // NOTE: the snapshot is a data buffer; it is only read while out_valid is high, so it has no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int r = 0; r < ROWS; r++) begin
                snap[r] <= C_in[r*ROW_BITS +: ROW_BITS];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_row   <= '0;
            drain_ack <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            drain_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (drain) begin
                        state     <= STREAM;
                        out_row   <= '0;
                        drain_ack <= 1'b1;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_last  <= (ROWS == 1);
                    end
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_row   <= '0;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_row  <= out_row + ROW_W'(1);
                            out_last <= (out_row == ROW_W'(ROWS - 2));
                        end
                    end
                end
            endcase
        end
    end

    // Row data is clamped on the way out; the snapshot is frozen while streaming,
    // so the beat holds stable under backpressure.
    assign cur_row = snap[out_row];

    for (genvar c = 0; c < COLS; c++) begin : g_col
        systolic_sat_clamp #(
            .IN_W  (ACC_W),
            .OUT_W (OUT_WIDTH)
        ) u_clamp (
            .in_val  (cur_row[c*ACC_W +: ACC_W]),
            .out_val (clamped[c*OUT_WIDTH +: OUT_WIDTH]),
            .sat     (sat_col[c])
        );
    end

    assign out_data = out_valid ? clamped : '0;
    assign out_sat  = out_valid && (|sat_col);

endmodule

// File: tb/tb_systolic_result_drainer.sv
// Bench for systolic_result_drainer: three instances (8x8 pass-through, 8x8 clamped
// to 8 bits, 1x4) checked against a tile-level reference model.
module tb_systolic_result_drainer;

    localparam int R  = 8;
    localparam int C  = 8;
    localparam int AW = 16;
    localparam int OW = 16;
    localparam int SW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // main instance: 8x8, OUT_WIDTH=16
    logic              drain, drain_ack, busy, out_valid, out_ready, out_last, out_sat;
    logic [AW*R*C-1:0] c_in;
    logic [C*OW-1:0]   out_data;
    logic [2:0]        out_row;

    // saturating instance: 8x8, OUT_WIDTH=8
    logic              s_drain, s_drain_ack, s_busy, s_out_valid, s_out_ready, s_out_last, s_out_sat;
    logic [AW*R*C-1:0] s_c_in;
    logic [C*SW-1:0]   s_out_data;
    logic [2:0]        s_out_row;

    // single-row instance: 1x4, OUT_WIDTH=16
    logic              o_drain, o_drain_ack, o_busy, o_out_valid, o_out_ready, o_out_last, o_out_sat;
    logic [AW*4-1:0]   o_c_in;
    logic [4*OW-1:0]   o_out_data;
    logic [0:0]        o_out_row;

    systolic_result_drainer #(.DATA_WIDTH(8), .ROWS(R), .COLS(C), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .drain(drain), .C_in(c_in), .drain_ack(drain_ack),
        .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_last(out_last), .out_sat(out_sat));

    systolic_result_drainer #(.DATA_WIDTH(8), .ROWS(R), .COLS(C), .OUT_WIDTH(SW)) dut_s (
        .clk(clk), .rst_n(rst_n), .drain(s_drain), .C_in(s_c_in), .drain_ack(s_drain_ack),
        .busy(s_busy), .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_row(s_out_row), .out_last(s_out_last), .out_sat(s_out_sat));

    systolic_result_drainer #(.DATA_WIDTH(8), .ROWS(1), .COLS(4), .OUT_WIDTH(OW)) dut_1 (
        .clk(clk), .rst_n(rst_n), .drain(o_drain), .C_in(o_c_in), .drain_ack(o_drain_ack),
        .busy(o_busy), .out_data(o_out_data), .out_valid(o_out_valid), .out_ready(o_out_ready),
        .out_row(o_out_row), .out_last(o_out_last), .out_sat(o_out_sat));

    // Reference model state: what is being driven, and what the DUT should have captured.
    int drive_tile [R][C];
    int cap_tile   [R][C];
    int s_tile     [R][C];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clampv(input int x, input int w);
        int mx, mn;
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        if (x > mx) return mx;
        if (x < mn) return mn;
        return x;
    endfunction

    function automatic logic [C*OW-1:0] exp_data(input int r);
        logic [C*OW-1:0] v;
        int e;
        for (int c = 0; c < C; c++) begin
            e = clampv(cap_tile[r][c], OW);
            v[c*OW +: OW] = e[OW-1:0];
        end
        return v;
    endfunction

    function automatic logic exp_sat(input int r);
        logic s;
        s = 1'b0;
        for (int c = 0; c < C; c++) begin
            if (clampv(cap_tile[r][c], OW) != cap_tile[r][c]) s = 1'b1;
        end
        return s;
    endfunction

    task automatic apply_tile();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                c_in[(r*C+c)*AW +: AW] = drive_tile[r][c][AW-1:0];
    endtask

    function automatic int rand_acc();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    // Called at a negedge with DUT idle; returns at the negedge after the capture edge.
    task automatic capture(input bit hold);
        drain = 1'b1;
        cap_tile = drive_tile;
        @(posedge clk);
        @(negedge clk);
        if (!hold) drain = 1'b0;
    endtask

    // mode 0: always ready, 1: alternating 1010.., 2: random. Stops after stop_at transfers.
    task automatic stream_tile(input int mode, input int stop_at, input int stall_row);
        int  r = 0;
        int  cyc = 0;
        int  stall_cnt = 0;
        logic rdy;
        while (r < stop_at && cyc < 400) begin
            check("ack", drain_ack, cyc == 0);
            check("valid", out_valid, 1'b1);
            check("busy", busy, 1'b1);
            check("row", out_row, r);
            check("last", out_last, r == R - 1);
            check("data", out_data, exp_data(r));
            check("sat", out_sat, exp_sat(r));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(1));
            endcase
            if (r == stall_row && stall_cnt < 3) begin
                rdy = 1'b0;
                stall_cnt++;
            end
            out_ready = rdy;
            @(posedge clk);
            if (rdy) r++;
            @(negedge clk);
            cyc++;
        end
        check("transfer_budget", r, stop_at);
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_row"}, out_row, 3'd0);
        check({tag, "_last"}, out_last, 1'b0);
        check({tag, "_ack"}, drain_ack, 1'b0);
        check({tag, "_data"}, out_data, '0);
    endtask

    initial begin
        logic [C*SW-1:0] s_exp;
        logic            s_sat_exp;
        logic [4*OW-1:0] o_exp;
        int              e;

        rst_n = 1'b0;
        drain = 1'b0; out_ready = 1'b0; c_in = '0;
        s_drain = 1'b0; s_out_ready = 1'b0; s_c_in = '0;
        o_drain = 1'b0; o_out_ready = 1'b0; o_c_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_sat", out_sat, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp tile, back-to-back beats.
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                drive_tile[r][c] = r * 16 + c;
        apply_tile();
        capture(1'b0);
        stream_tile(0, R, -1);
        check_idle("t1_after");

        // Same tile with alternating ready and a 3-cycle stall on row 4.
        @(negedge clk);
        capture(1'b0);
        stream_tile(1, R, 4);
        check_idle("t2_after");

        // drain held through the stream; C_in rewritten after capture.
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                drive_tile[r][c] = rand_acc();
        apply_tile();
        capture(1'b1);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                drive_tile[r][c] = 32767;
        apply_tile();
        stream_tile(2, R, -1);
        check_idle("t4_gap");
        cap_tile = drive_tile;
        @(posedge clk);
        @(negedge clk);
        drain = 1'b0;
        stream_tile(0, R, -1);
        check_idle("t4_after");

        // Reset while stalled on row 3, with drain asserted on the reset edge.
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                drive_tile[r][c] = rand_acc();
        apply_tile();
        capture(1'b0);
        stream_tile(0, 3, -1);
        @(posedge clk);
        @(negedge clk);
        check("t5_stall_row", out_row, 3'd3);
        check("t5_stall_data", out_data, exp_data(3));
        rst_n = 1'b0;
        drain = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("t5_reset");
        rst_n = 1'b1;
        drain = 1'b0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                drive_tile[r][c] = rand_acc();
        apply_tile();
        capture(1'b0);
        stream_tile(0, R, -1);
        check_idle("t5_after");

        // Random tiles under random backpressure.
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    drive_tile[r][c] = rand_acc();
            apply_tile();
            capture(1'b0);
            stream_tile(2, R, -1);
            check_idle("rand_after");
        end

        // Saturating instance (OUT_WIDTH=8).
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                s_tile[r][c] = (r < 4) ? 0 : (r < 6) ? int'($urandom_range(255)) - 128 : rand_acc();
        s_tile[0][0] = 300;
        s_tile[1][3] = -300;
        s_tile[2][0] = 127;
        s_tile[2][1] = -128;
        s_tile[2][2] = -1;
        for (int c = 0; c < C; c++) s_tile[3][c] = -1;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                s_c_in[(r*C+c)*AW +: AW] = s_tile[r][c][AW-1:0];
        s_drain = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_drain = 1'b0;
        check("s_ack", s_drain_ack, 1'b1);
        s_out_ready = 1'b1;
        for (int r = 0; r < R; r++) begin
            s_sat_exp = 1'b0;
            for (int c = 0; c < C; c++) begin
                e = clampv(s_tile[r][c], SW);
                s_exp[c*SW +: SW] = e[SW-1:0];
                if (e != s_tile[r][c]) s_sat_exp = 1'b1;
            end
            check("s_valid", s_out_valid, 1'b1);
            check("s_row", s_out_row, r);
            check("s_last", s_out_last, r == R - 1);
            check("s_data", s_out_data, s_exp);
            check("s_sat", s_out_sat, s_sat_exp);
            @(posedge clk);
            @(negedge clk);
        end
        s_out_ready = 1'b0;
        check("s_done_valid", s_out_valid, 1'b0);
        check("s_done_busy", s_busy, 1'b0);

        // Single-row instance: elem (0,c) = -c.
        for (int c = 0; c < 4; c++) begin
            e = -c;
            o_c_in[c*AW +: AW] = e[AW-1:0];
            o_exp[c*OW +: OW] = e[OW-1:0];
        end
        o_drain = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_drain = 1'b0;
        check("o_ack", o_drain_ack, 1'b1);
        check("o_busy", o_busy, 1'b1);
        check("o_valid", o_out_valid, 1'b1);
        check("o_last", o_out_last, 1'b1);
        check("o_row", o_out_row, 1'b0);
        check("o_data", o_out_data, o_exp);
        check("o_sat", o_out_sat, 1'b0);
        o_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_out_ready = 1'b0;
        check("o_done_valid", o_out_valid, 1'b0);
        check("o_done_busy", o_busy, 1'b0);
        check("o_done_last", o_out_last, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
